// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and its environment:
// per-stage readies and restart request in, per-stage resets and status out.
interface reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 4
);
    logic [NUM_STAGES-1:0] STAGE_READY;
    logic                  SW_RESET_REQ;
    logic [NUM_STAGES-1:0] STAGE_RESET_N;
    logic                  SEQ_DONE;
    logic                  SEQ_ERROR;
    logic [2:0]            ERR_STAGE;

    modport master (
        output STAGE_READY,
        output SW_RESET_REQ,
        input  STAGE_RESET_N,
        input  SEQ_DONE,
        input  SEQ_ERROR,
        input  ERR_STAGE
    );

    modport slave (
        input  STAGE_READY,
        input  SW_RESET_REQ,
        output STAGE_RESET_N,
        output SEQ_DONE,
        output SEQ_ERROR,
        output ERR_STAGE
    );
endinterface

// File: rtl/reset_sequencer.sv
// Releases per-domain active-low resets in order, each after a settle delay and,
// for masked stages, only once that stage reports ready; handles timeout and restart.
module reset_sequencer #(
    parameter int unsigned           NUM_STAGES     = 4,
    parameter int unsigned           DELAY_CYCLES   = 16,
    parameter int unsigned           TIMEOUT_CYCLES = 1024,
    parameter logic [NUM_STAGES-1:0] READY_MASK     = NUM_STAGES'(4'b0011),
    parameter int unsigned           CNT_WIDTH      = 16
) (
    input  logic              CLK,
    input  logic              FABRIC_RESET_N,
    reset_sequencer_if.slave  seq
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_DELAY      = 3'd1;
    localparam logic [2:0] S_WAIT_READY = 3'd2;
    localparam logic [2:0] S_DONE       = 3'd3;
    localparam logic [2:0] S_ERROR      = 3'd4;

    logic [NUM_STAGES-1:0] sync1_q, sync1_d;
    logic [NUM_STAGES-1:0] sync2_q, sync2_d;
    logic [2:0]            state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [2:0]            err_stage_q, err_stage_d;

    logic [NUM_STAGES-1:0] rdy;
    logic [NUM_STAGES-1:0] sel;
    logic                  last;

    always_comb begin
        sync1_d       = seq.STAGE_READY;
        sync2_d       = sync1_q;
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        stage_rst_n_d = stage_rst_n_q;
        done_d        = done_q;
        error_d       = error_q;
        err_stage_d   = err_stage_q;

        rdy  = sync2_q;
        // One-hot select of the current stage avoids a variable part-select.
        sel  = {{(NUM_STAGES-1){1'b0}}, 1'b1} << idx_q;
        last = (idx_q == 3'(NUM_STAGES - 1));

        if (seq.SW_RESET_REQ) begin
            state_d       = S_IDLE;
            idx_d         = '0;
            cnt_d         = '0;
            stage_rst_n_d = '0;
            done_d        = 1'b0;
            error_d       = 1'b0;
            err_stage_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_DELAY;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                S_DELAY: begin
                    if (cnt_q == CNT_WIDTH'(DELAY_CYCLES - 1)) begin
                        stage_rst_n_d = stage_rst_n_q | sel;
                        cnt_d         = '0;
                        if (|(READY_MASK & sel)) begin
                            state_d = S_WAIT_READY;
                        end else if (last) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_READY: begin
                    if (|(rdy & sel)) begin
                        cnt_d = '0;
                        if (last) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DELAY;
                            idx_d   = idx_q + 3'd1;
                        end
                    end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        state_d       = S_ERROR;
                        cnt_d         = '0;
                        stage_rst_n_d = stage_rst_n_q & ~sel;
                        error_d       = 1'b1;
                        err_stage_d   = idx_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Losing any gated ready pulls every domain back into reset.
                    if ((rdy & READY_MASK) != READY_MASK) begin
                        state_d       = S_IDLE;
                        idx_d         = '0;
                        cnt_d         = '0;
                        stage_rst_n_d = '0;
                        done_d        = 1'b0;
                    end
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d       = S_IDLE;
                    idx_d         = '0;
                    cnt_d         = '0;
                    stage_rst_n_d = '0;
                    done_d        = 1'b0;
                    error_d       = 1'b0;
                    err_stage_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!FABRIC_RESET_N) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            stage_rst_n_q <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_stage_q   <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            stage_rst_n_q <= stage_rst_n_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_stage_q   <= err_stage_d;
        end
    end

    assign seq.STAGE_RESET_N = stage_rst_n_q;
    assign seq.SEQ_DONE      = done_q;
    assign seq.SEQ_ERROR     = error_q;
    assign seq.ERR_STAGE     = err_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a deadline-based reference model queues expected
// output changes with their cycle stamps; a monitor pops one per observed change.
module tb_reset_sequencer;

    localparam int unsigned NS   = 4;
    localparam int          DLY  = 16;
    localparam int          TMO  = 1024;
    localparam logic [3:0]  MASK = 4'b0011;
    localparam int          MAXC = 40000;

    typedef enum logic [2:0] {M_IDLE, M_SETTLE, M_WAIT, M_DONE, M_ERR} mode_t;
    typedef struct packed {
        int         cyc;
        logic [8:0] v;
    } ev_t;

    logic CLK = 1'b0;
    logic FABRIC_RESET_N = 1'b0;

    reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

    reset_sequencer #(
        .NUM_STAGES    (NS),
        .DELAY_CYCLES  (DLY),
        .TIMEOUT_CYCLES(TMO),
        .READY_MASK    (MASK),
        .CNT_WIDTH     (16)
    ) dut (
        .CLK           (CLK),
        .FABRIC_RESET_N(FABRIC_RESET_N),
        .seq           (bus.slave)
    );

    always #5 CLK = ~CLK;

    ev_t        sb[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    // Reference model state: what has been released and when the next thing is due.
    mode_t      mode = M_IDLE;
    logic [1:0] stage = 2'd0;
    int         release_at = 0;
    int         give_up_at = 0;
    logic [3:0] m_rst_n = 4'h0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    logic [2:0] m_err_stage = 3'd0;
    logic [8:0] last_pushed = 9'h0;
    bit         pushed_any = 1'b0;
    logic [3:0] sr_hist [0:MAXC-1];
    bit         rst_hist[0:MAXC-1];

    logic [8:0] seen = 9'h0;
    bit         have_seen = 1'b0;
    logic [8:0] cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic go_idle();
        mode    = M_IDLE;
        stage   = 2'd0;
        m_rst_n = 4'h0;
        m_done  = 1'b0;
    endtask

    task automatic model_step(input logic rst, input logic req, input logic [3:0] ready);
        logic [3:0] rdy;
        logic [8:0] vec;
        cyc++;
        rst_hist[cyc] = rst;
        sr_hist[cyc]  = ready;
        // Two-flop synchronizer: decisions at this edge see the input sampled two edges ago.
        rdy = (cyc >= 3 && rst_hist[cyc-1] && rst_hist[cyc-2]) ? sr_hist[cyc-2] : 4'h0;
        if (!rst || req) begin
            go_idle();
            m_err       = 1'b0;
            m_err_stage = 3'd0;
        end else begin
            case (mode)
                M_IDLE: begin
                    mode       = M_SETTLE;
                    stage      = 2'd0;
                    release_at = cyc + DLY;
                end
                M_SETTLE: if (cyc == release_at) begin
                    m_rst_n[stage] = 1'b1;
                    if (MASK[stage]) begin
                        mode       = M_WAIT;
                        give_up_at = cyc + TMO;
                    end else if (stage == 2'd3) begin
                        mode   = M_DONE;
                        m_done = 1'b1;
                    end else begin
                        stage      = stage + 2'd1;
                        release_at = cyc + DLY;
                    end
                end
                M_WAIT: begin
                    if (rdy[stage]) begin
                        if (stage == 2'd3) begin
                            mode   = M_DONE;
                            m_done = 1'b1;
                        end else begin
                            mode       = M_SETTLE;
                            stage      = stage + 2'd1;
                            release_at = cyc + DLY;
                        end
                    end else if (cyc == give_up_at) begin
                        mode           = M_ERR;
                        m_rst_n[stage] = 1'b0;
                        m_err          = 1'b1;
                        m_err_stage    = {1'b0, stage};
                    end
                end
                M_DONE: if ((rdy & MASK) != MASK) go_idle();
                default: ;
            endcase
        end
        vec = {m_rst_n, m_done, m_err, m_err_stage};
        if (!pushed_any || vec != last_pushed) begin
            sb.push_back('{cyc: cyc, v: vec});
            last_pushed = vec;
            pushed_any  = 1'b1;
        end
    endtask

    task automatic tick(input logic rst, input logic req, input logic [3:0] ready);
        FABRIC_RESET_N   = rst;
        bus.SW_RESET_REQ = req;
        bus.STAGE_READY  = ready;
        @(posedge CLK);
        model_step(rst, req, ready);
        #1;
    endtask

    task automatic run(input int n, input logic [3:0] ready);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, ready);
    endtask

    // Monitor: every observed output change must match the next queued expectation.
    initial begin
        ev_t e;
        forever begin
            @(negedge CLK);
            cur = {bus.STAGE_RESET_N, bus.SEQ_DONE, bus.SEQ_ERROR, bus.ERR_STAGE};
            if (cyc > 0 && (!have_seen || cur !== seen)) begin
                have_seen = 1'b1;
                seen      = cur;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_change: got %0h expected no change (cycle %0d)", cur, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    chk("event_value", 32'(cur), 32'(e.v));
                end
            end
        end
    end

    initial begin
        bus.STAGE_READY  = 4'hF;
        bus.SW_RESET_REQ = 1'b0;

        // Reset, then an unobstructed sequence with all readies already high.
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 4'hF);
        run(100, 4'hF);

        // Ready loss in DONE forces a full re-sequence.
        run(5, 4'b1101);
        run(100, 4'hF);

        // Stage 0 never ready: timeout, then software restart clears the error.
        tick(1'b1, 1'b1, 4'b1110);
        run(1100, 4'b1110);
        tick(1'b1, 1'b1, 4'hF);
        run(100, 4'hF);

        // Stage 1 ready arrives 50 cycles after its release.
        tick(1'b1, 1'b1, 4'b1101);
        run(34 + 50, 4'b1101);
        run(100, 4'hF);

        // Fabric reset for one cycle while waiting on stage 1.
        tick(1'b1, 1'b1, 4'b1101);
        run(40, 4'b1101);
        tick(1'b0, 1'b0, 4'b1101);
        run(100, 4'hF);

        // Software restart on the very edge stage 0 would be released.
        tick(1'b1, 1'b1, 4'hF);
        run(16, 4'hF);
        tick(1'b1, 1'b1, 4'hF);
        run(100, 4'hF);

        // Randomized readies, restarts and fabric resets.
        for (int s = 0; s < 250; s++) begin
            int unsigned len;
            logic [3:0]  r;
            len = $urandom_range(1, 60);
            r   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            for (int j = 0; j < int'(len); j++) begin
                tick(($urandom_range(0, 127) != 0), ($urandom_range(0, 63) == 0), r);
            end
        end
        run(120, 4'hF);

        @(negedge CLK);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_outputs", 32'({bus.STAGE_RESET_N, bus.SEQ_DONE, bus.SEQ_ERROR, bus.ERR_STAGE}),
            32'(last_pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
